// File: rtl/alarm_controller.sv
// Alarm path sequencer: set-button auto-repeat pulses, alarm-time match detection,
// and the ring/snooze/stop state machine that drives the buzzer.
module alarm_controller #(
    parameter int unsigned REPEAT_DELAY_CYCLES  = 32'd2500000,
    parameter int unsigned REPEAT_PERIOD_CYCLES = 32'd500000,
    parameter int unsigned SNOOZE_CYCLES        = 32'd2700000000,
    parameter int unsigned RING_TIMEOUT_CYCLES  = 32'd3000000000,
    parameter int unsigned BUZZ_HALF_CYCLES     = 32'd2500
) (
    input  logic        i_Clk_5MHz,
    input  logic        i_Reset,
    input  logic        i_Alarm_Enable,
    input  logic        i_Set_Mode,
    input  logic        i_Btn_Minutes_Up,
    input  logic        i_Btn_Minutes_Down,
    input  logic        i_Btn_Hours_Up,
    input  logic        i_Btn_Hours_Down,
    input  logic        i_Snooze,
    input  logic        i_Stop,
    input  logic [31:0] i_Clock_Time,
    input  logic        i_Clock_PM,
    input  logic [31:0] i_Alarm_Time,
    input  logic        i_Alarm_PM,
    output logic        o_Minutes_Inc,
    output logic        o_Minutes_Dec,
    output logic        o_Hours_Inc,
    output logic        o_Hours_Dec,
    output logic        o_Buzzer,
    output logic        o_Ringing,
    output logic        o_Snoozing,
    output logic [1:0]  o_State
);

    typedef enum logic [1:0] {
        StDisarmed = 2'd0,
        StArmed    = 2'd1,
        StRinging  = 2'd2,
        StSnooze   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic        match_q, match_d;
    logic        snooze_prev_q, snooze_prev_d;
    logic        stop_prev_q, stop_prev_d;
    logic [3:0]  active_q, active_d;
    logic [3:0]  pulse_q, pulse_d;
    logic [31:0] rpt_cnt_q, rpt_cnt_d;
    logic [31:0] phase_q, phase_d;
    logic        buzz_q, buzz_d;

    logic [3:0]  btn_held;
    logic [3:0]  btn_sel;
    logic        trigger;
    logic        snooze_edge;
    logic        stop_edge;

    // Seconds and centiseconds never take part in the match.
    logic        unused_time_bits;
    assign unused_time_bits = ^{i_Clock_Time[15:0], i_Alarm_Time[15:0]};

    assign btn_held = {i_Btn_Minutes_Up, i_Btn_Minutes_Down, i_Btn_Hours_Up, i_Btn_Hours_Down};

    always_comb begin
        match_d       = (i_Clock_Time[31:16] == i_Alarm_Time[31:16]) && (i_Clock_PM == i_Alarm_PM);
        snooze_prev_d = i_Snooze;
        stop_prev_d   = i_Stop;
        trigger       = match_d && !match_q;
        snooze_edge   = i_Snooze && !snooze_prev_q;
        stop_edge     = i_Stop && !stop_prev_q;
    end

    // Priority select: bit 3 (Minutes_Up) down to bit 0 (Hours_Down).
    always_comb begin
        btn_sel = 4'b0000;
        if (btn_held[3]) begin
            btn_sel = 4'b1000;
        end else if (btn_held[2]) begin
            btn_sel = 4'b0100;
        end else if (btn_held[1]) begin
            btn_sel = 4'b0010;
        end else if (btn_held[0]) begin
            btn_sel = 4'b0001;
        end
    end

    always_comb begin
        active_d  = active_q;
        rpt_cnt_d = rpt_cnt_q;
        pulse_d   = 4'b0000;
        if (!i_Set_Mode || (btn_sel == 4'b0000)) begin
            active_d  = 4'b0000;
            rpt_cnt_d = 32'd0;
        end else if (btn_sel != active_q) begin
            active_d  = btn_sel;
            rpt_cnt_d = REPEAT_DELAY_CYCLES;
            pulse_d   = btn_sel;
        end else if (rpt_cnt_q <= 32'd1) begin
            rpt_cnt_d = REPEAT_PERIOD_CYCLES;
            pulse_d   = btn_sel;
        end else begin
            rpt_cnt_d = rpt_cnt_q - 32'd1;
        end
    end

    // State register.
    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            state_q <= StDisarmed;
            timer_q <= 32'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // Next state; the shared timer counts down while RINGING or SNOOZE.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        unique case (state_q)
            StDisarmed: begin
                if (i_Alarm_Enable) begin
                    state_d = StArmed;
                end
            end
            StArmed: begin
                if (!i_Alarm_Enable) begin
                    state_d = StDisarmed;
                end else if (trigger && !i_Set_Mode) begin
                    state_d = StRinging;
                    timer_d = RING_TIMEOUT_CYCLES;
                end
            end
            StRinging: begin
                timer_d = timer_q - 32'd1;
                if (!i_Alarm_Enable) begin
                    state_d = StDisarmed;
                end else if (stop_edge) begin
                    state_d = StArmed;
                end else if (snooze_edge) begin
                    state_d = StSnooze;
                    timer_d = SNOOZE_CYCLES;
                end else if (timer_q <= 32'd1) begin
                    state_d = StArmed;
                end
            end
            StSnooze: begin
                timer_d = timer_q - 32'd1;
                if (!i_Alarm_Enable) begin
                    state_d = StDisarmed;
                end else if (stop_edge) begin
                    state_d = StArmed;
                end else if (timer_q <= 32'd1) begin
                    state_d = StRinging;
                    timer_d = RING_TIMEOUT_CYCLES;
                end
            end
            default: begin
                state_d = StDisarmed;
            end
        endcase
    end

    // Tone phase restarts on every entry into RINGING.
    always_comb begin
        phase_d = 32'd0;
        buzz_d  = 1'b0;
        if ((state_d == StRinging) && (state_q == StRinging)) begin
            if (phase_q >= BUZZ_HALF_CYCLES - 32'd1) begin
                buzz_d = !buzz_q;
            end else begin
                phase_d = phase_q + 32'd1;
                buzz_d  = buzz_q;
            end
        end
    end

    always_ff @(posedge i_Clk_5MHz) begin
        if (i_Reset) begin
            match_q       <= 1'b1;
            snooze_prev_q <= 1'b0;
            stop_prev_q   <= 1'b0;
            active_q      <= 4'b0000;
            pulse_q       <= 4'b0000;
            rpt_cnt_q     <= 32'd0;
            phase_q       <= 32'd0;
            buzz_q        <= 1'b0;
        end else begin
            match_q       <= match_d;
            snooze_prev_q <= snooze_prev_d;
            stop_prev_q   <= stop_prev_d;
            active_q      <= active_d;
            pulse_q       <= pulse_d;
            rpt_cnt_q     <= rpt_cnt_d;
            phase_q       <= phase_d;
            buzz_q        <= buzz_d;
        end
    end

    // Outputs decode registered state only.
    always_comb begin
        o_State       = state_q;
        o_Ringing     = (state_q == StRinging);
        o_Snoozing    = (state_q == StSnooze);
        o_Buzzer      = buzz_q && (state_q == StRinging);
        o_Minutes_Inc = pulse_q[3];
        o_Minutes_Dec = pulse_q[2];
        o_Hours_Inc   = pulse_q[1];
        o_Hours_Dec   = pulse_q[0];
    end

endmodule

// File: tb/tb_alarm_controller.sv
// Self-checking bench for alarm_controller: directed vector table, hand-written
// multi-cycle sequences, and random stimulus against a timestamp-based model.
module tb_alarm_controller;

    localparam int DLY  = 10;
    localparam int PER  = 4;
    localparam int SNZ  = 50;
    localparam int RING = 100;
    localparam int HALF = 3;

    localparam logic [31:0] T14  = 32'h07140000;
    localparam logic [31:0] T15  = 32'h07150000;
    localparam logic [31:0] T15S = 32'h07153042;
    localparam logic [31:0] T16  = 32'h07160000;

    typedef struct packed {
        logic        rst;
        logic        en;
        logic        set;
        logic [3:0]  btn;
        logic [31:0] ct;
        logic        cpm;
        logic        apm;
        logic        snz;
        logic        stp;
    } in_t;

    typedef struct packed {
        in_t         vin;
        logic [15:0] reps;
        logic [1:0]  st;
        logic        bz;
        logic [3:0]  pl;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, en, set_mode, btn_mu, btn_md, btn_hu, btn_hd, snz, stp;
    logic [31:0] clock_time;
    logic [31:0] alarm_time = T15;
    logic        clock_pm, alarm_pm;
    logic        min_inc, min_dec, hr_inc, hr_dec, buzzer, ringing, snoozing;
    logic [1:0]  state;
    logic [8:0]  obs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Reference model: timestamps of entry/hold start instead of down-counters.
    int       m_st = 0;
    int       m_entry = 0;
    bit       m_mprev = 1'b1;
    bit       m_sprev = 1'b0;
    bit       m_tprev = 1'b0;
    int       m_act = -1;
    int       m_t0 = 0;
    logic [3:0] m_pl = 4'b0000;

    always #5 clk = ~clk;

    alarm_controller #(
        .REPEAT_DELAY_CYCLES (DLY),
        .REPEAT_PERIOD_CYCLES(PER),
        .SNOOZE_CYCLES       (SNZ),
        .RING_TIMEOUT_CYCLES (RING),
        .BUZZ_HALF_CYCLES    (HALF)
    ) dut (
        .i_Clk_5MHz        (clk),
        .i_Reset           (rst),
        .i_Alarm_Enable    (en),
        .i_Set_Mode        (set_mode),
        .i_Btn_Minutes_Up  (btn_mu),
        .i_Btn_Minutes_Down(btn_md),
        .i_Btn_Hours_Up    (btn_hu),
        .i_Btn_Hours_Down  (btn_hd),
        .i_Snooze          (snz),
        .i_Stop            (stp),
        .i_Clock_Time      (clock_time),
        .i_Clock_PM        (clock_pm),
        .i_Alarm_Time      (alarm_time),
        .i_Alarm_PM        (alarm_pm),
        .o_Minutes_Inc     (min_inc),
        .o_Minutes_Dec     (min_dec),
        .o_Hours_Inc       (hr_inc),
        .o_Hours_Dec       (hr_dec),
        .o_Buzzer          (buzzer),
        .o_Ringing         (ringing),
        .o_Snoozing        (snoozing),
        .o_State           (state)
    );

    assign obs = {state, ringing, snoozing, buzzer, min_inc, min_dec, hr_inc, hr_dec};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [8:0] model_obs();
        logic bz;
        logic [1:0] st;
        bz = 1'b0;
        st = 2'(m_st);
        if (m_st == 2) bz = (((cyc - m_entry) / HALF) % 2) == 1;
        return {st, m_st == 2, m_st == 3, bz, m_pl};
    endfunction

    task automatic model_step(input in_t v);
        bit match, trig, snz_e, stp_e;
        int act;
        match = (v.ct[31:16] == alarm_time[31:16]) && (v.cpm == v.apm);
        if (v.rst) begin
            m_st = 0; m_mprev = 1'b1; m_sprev = 1'b0; m_tprev = 1'b0;
            m_act = -1; m_pl = 4'b0000;
        end else begin
            trig  = match && !m_mprev;
            snz_e = v.snz && !m_sprev;
            stp_e = v.stp && !m_tprev;
            m_mprev = match; m_sprev = v.snz; m_tprev = v.stp;
            case (m_st)
                0: if (v.en) m_st = 1;
                1: begin
                    if (!v.en) m_st = 0;
                    else if (trig && !v.set) begin m_st = 2; m_entry = cyc + 1; end
                end
                2: begin
                    if (!v.en) m_st = 0;
                    else if (stp_e) m_st = 1;
                    else if (snz_e) begin m_st = 3; m_entry = cyc + 1; end
                    else if (cyc + 1 - m_entry == RING) m_st = 1;
                end
                default: begin
                    if (!v.en) m_st = 0;
                    else if (stp_e) m_st = 1;
                    else if (cyc + 1 - m_entry == SNZ) begin m_st = 2; m_entry = cyc + 1; end
                end
            endcase
            act = -1;
            if (v.set) for (int b = 0; b < 4; b++) if (v.btn[b]) act = b;
            m_pl = 4'b0000;
            if (act >= 0) begin
                if (act != m_act) begin
                    m_t0 = cyc;
                    m_pl[act] = 1'b1;
                end else if ((cyc - m_t0 >= DLY) && ((cyc - m_t0 - DLY) % PER == 0)) begin
                    m_pl[act] = 1'b1;
                end
            end
            m_act = act;
        end
        cyc++;
    endtask

    task automatic step(input in_t v);
        rst = v.rst; en = v.en; set_mode = v.set;
        {btn_mu, btn_md, btn_hu, btn_hd} = v.btn;
        clock_time = v.ct; clock_pm = v.cpm; alarm_pm = v.apm;
        snz = v.snz; stp = v.stp;
        model_step(v);
        @(posedge clk);
        #1;
        check("model", {23'd0, obs}, {23'd0, model_obs()});
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic s, input logic [3:0] b,
                                input logic [31:0] ct, input logic apm, input logic sz,
                                input logic sp, input int reps, input logic [1:0] st,
                                input logic bz, input logic [3:0] pl);
        vec_t v;
        v.vin.rst = r; v.vin.en = e; v.vin.set = s; v.vin.btn = b; v.vin.ct = ct;
        v.vin.cpm = 1'b0; v.vin.apm = apm; v.vin.snz = sz; v.vin.stp = sp;
        v.reps = 16'(reps); v.st = st; v.bz = bz; v.pl = pl;
        return v;
    endfunction

    initial begin
        vec_t tbl[$];
        in_t  cur;
        int   n;
        logic exp_pulse;

        // Priority and set-mode gating (alarm disabled).
        tbl.push_back(mk(0, 0, 1, 4'b0001, T16, 0, 0, 0, 1, 0, 0, 4'b0001));
        tbl.push_back(mk(0, 0, 1, 4'b0001, T16, 0, 0, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 1, 4'b1001, T16, 0, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 0, 1, 4'b1001, T16, 0, 0, 0, 9, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 1, 4'b1001, T16, 0, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 0, 1, 4'b1001, T16, 0, 0, 0, 3, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 1, 4'b1001, T16, 0, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 0, 1, 4'b0001, T16, 0, 0, 0, 1, 0, 0, 4'b0001));
        tbl.push_back(mk(0, 0, 1, 4'b0000, T16, 0, 0, 0, 2, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 4'b1000, T16, 0, 0, 0, 3, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 1, 4'b1000, T16, 0, 0, 0, 1, 0, 0, 4'b1000));
        tbl.push_back(mk(0, 0, 0, 4'b0000, T16, 0, 0, 0, 1, 0, 0, 4'b0000));
        // Ring, buzzer phase, stop, no re-ring in the same minute.
        tbl.push_back(mk(0, 1, 0, 4'b0000, T14, 0, 0, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 1, 2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15S, 0, 0, 0, 2, 2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15S, 0, 0, 0, 3, 2, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15S, 0, 0, 0, 3, 2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15S, 0, 0, 0, 1, 2, 1, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15S, 0, 0, 1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15S, 0, 0, 1, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 5, 1, 0, 4'b0000));
        // PM mismatch, then match under set mode.
        tbl.push_back(mk(0, 1, 0, 4'b0000, T16, 0, 0, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 1, 0, 0, 3, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T16, 0, 0, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 1, 4'b0000, T15, 0, 0, 0, 2, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 2, 1, 0, 4'b0000));
        // Simultaneous stop and snooze: stop wins.
        tbl.push_back(mk(0, 1, 0, 4'b0000, T16, 0, 0, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 1, 2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 1, 1, 1, 1, 0, 4'b0000));
        // Reset mid-ring with the match still present.
        tbl.push_back(mk(0, 1, 0, 4'b0000, T16, 0, 0, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 1, 2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 2, 2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 1, 2, 1, 4'b0000));
        tbl.push_back(mk(1, 1, 0, 4'b0000, T15, 0, 0, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 4, 1, 0, 4'b0000));
        // Snooze, re-press ignored, disable during SNOOZE.
        tbl.push_back(mk(0, 1, 0, 4'b0000, T16, 0, 0, 0, 1, 1, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 1, 2, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 1, 0, 1, 3, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 0, 0, 2, 3, 0, 4'b0000));
        tbl.push_back(mk(0, 1, 0, 4'b0000, T15, 0, 1, 0, 1, 3, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 4'b0000, T15, 0, 0, 0, 1, 0, 0, 4'b0000));
        tbl.push_back(mk(0, 0, 0, 4'b0000, T15, 0, 0, 0, 2, 0, 0, 4'b0000));

        // Reset state.
        cur = '0;
        cur.rst = 1'b1; cur.ct = T15;
        step(cur);
        step(cur);
        check("reset_outputs", {23'd0, obs}, 32'd0);

        // Auto-repeat: Minutes_Up held from relative cycle 0 for 25 cycles.
        cur = '0;
        cur.set = 1'b1; cur.ct = T16;
        step(cur);
        step(cur);
        cur.btn = 4'b1000;
        for (int k = 0; k < 25; k++) begin
            step(cur);
            exp_pulse = (k + 1 == 1) || (k + 1 == 11) || (k + 1 == 15) || (k + 1 == 19) ||
                        (k + 1 == 23);
            check("repeat_pulse", {31'd0, min_inc}, {31'd0, exp_pulse});
            check("repeat_others", {29'd0, min_dec, hr_inc, hr_dec}, 32'd0);
        end
        cur.btn = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            step(cur);
            check("release_quiet", {28'd0, min_inc, min_dec, hr_inc, hr_dec}, 32'd0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            for (int r = 0; r < int'(tbl[i].reps); r++) begin
                step(tbl[i].vin);
                check($sformatf("vec%0d", i), {23'd0, obs},
                      {23'd0, tbl[i].st, tbl[i].st == 2'd2, tbl[i].st == 2'd3, tbl[i].bz,
                       tbl[i].pl});
            end
        end

        // Snooze length, then unattended ring timeout.
        cur = '0;
        cur.en = 1'b1; cur.ct = T16;
        step(cur);
        cur.ct = T15;
        step(cur);
        check("ring_start", {30'd0, state}, 32'd2);
        cur.snz = 1'b1;
        step(cur);
        check("snooze_start", {30'd0, state}, 32'd3);
        n = 1;
        for (int k = 0; k < 200; k++) begin
            cur.snz = (k == 10);
            step(cur);
            if (state == 2'd3) n++;
            else break;
        end
        check("snooze_len", n, SNZ);
        check("after_snooze", {30'd0, state}, 32'd2);
        check("buzz_reentry", {31'd0, buzzer}, 32'd0);
        cur.snz = 1'b0;
        n = 1;
        for (int k = 0; k < 300; k++) begin
            step(cur);
            if (state == 2'd2) n++;
            else break;
        end
        check("ring_len", n, RING);
        check("after_timeout", {30'd0, state}, 32'd1);

        // Random stimulus against the model.
        cur = '0;
        cur.en = 1'b1; cur.ct = T16;
        for (int k = 0; k < 4000; k++) begin
            cur.rst = ($urandom_range(199) == 0);
            if ($urandom_range(149) == 0) cur.en = !cur.en;
            if ($urandom_range(99) == 0) cur.set = !cur.set;
            if ($urandom_range(11) == 0) cur.btn = $urandom_range(1) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(14) == 0) begin
                case ($urandom_range(3))
                    0: cur.ct = T14;
                    1: cur.ct = T15;
                    2: cur.ct = T15S;
                    default: cur.ct = T16;
                endcase
                cur.cpm = ($urandom_range(3) == 0);
            end
            if ($urandom_range(299) == 0) cur.apm = !cur.apm;
            if ($urandom_range(79) == 0) cur.snz = !cur.snz;
            if ($urandom_range(119) == 0) cur.stp = !cur.stp;
            step(cur);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
